mem_stage_lsu: RTL and testbench

Load/store unit for the MEM stage of the five-stage MIPS pipeline. It consumes the EX/MEM register outputs (ALU result as address, forwarded store data, memory control bits) and runs a request/acknowledge transaction with data memory. While a transaction is outstanding it stalls all earlier stages. Load results are aligned and extended before they are handed to the MEM/WB register.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/lsu_align.sv | 61 ++++++
 rtl/mem_stage_lsu.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size codes,
// controller states and byte-lane constants.
package mem_pkg;

    localparam int         LANES  = 4;
    localparam int         WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [LANES-1:0] BE_BYTE0   = 4'b0001;
    localparam logic [LANES-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [LANES-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [LANES-1:0] BE_ALL     = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store-data replication and
// load extraction/extension. Misalignment detection exists only with UNALIGNED_TRAP_EN.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic [1:0]        addr_lo_i,
    input  logic              sign_ext_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [WORD_W-1:0] rdata_i,
    output logic [LANES-1:0]  be_o,
    output logic [WORD_W-1:0] wdata_o,
`ifdef UNALIGNED_TRAP_EN
    output logic              misaligned_o,
`endif
    output logic [WORD_W-1:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Size code 11 falls into the default arm and behaves as a word.
    always_comb begin
        be_o    = BE_ALL;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = BE_BYTE0 << addr_lo_i;
                wdata_o = {LANES{wdata_i[7:0]}};
                rdata_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                be_o = BE_ALL;
            end
            default: begin
                be_o = BE_ALL;
            end
        endcase
    end

`ifdef UNALIGNED_TRAP_EN
    always_comb begin
        misaligned_o = 1'b0;
        if (size_i == SZ_HALF) begin
            misaligned_o = addr_lo_i[0];
        end else if (size_i != SZ_BYTE) begin
            misaligned_o = |addr_lo_i;
        end
    end
`endif

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: request/ack handshake with data memory, pipeline stall
// and aligned load results. Optional misaligned-access trap via UNALIGNED_TRAP_EN.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [3:0]        dm_be_o,
    output logic [DATA_W-1:0] dm_wdata_o,
    input  logic              dm_ack_i,
    input  logic [DATA_W-1:0] dm_rdata_i,
    output logic [DATA_W-1:0] load_data_o,
`ifdef UNALIGNED_TRAP_EN
    output logic              addr_err_o,
`endif
    output logic              load_valid_o
);

    lsu_state_e        state_q, state_d;
    logic              dm_req_q, dm_we_q, load_valid_q, sign_ext_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic [3:0]        dm_be_q;
    logic [DATA_W-1:0] dm_wdata_q, load_data_q;
    logic [1:0]        size_q, addr_lo_q;

    logic              pending, issue, in_idle, stall;
    logic [1:0]        align_size, align_lo;
    logic [3:0]        align_be;
    logic [DATA_W-1:0] align_wdata, align_rdata;

    assign pending = mem_valid_i & (mem_read_i | mem_write_i);
    assign in_idle = (state_q == S_IDLE);

    // The aligner sees the live instruction while idle and the captured one afterwards.
    assign align_size = in_idle ? size_i : size_q;
    assign align_lo   = in_idle ? addr_i[1:0] : addr_lo_q;

`ifdef UNALIGNED_TRAP_EN
    logic misaligned;
    logic addr_err_q;

    assign issue      = pending & ~misaligned;
    assign addr_err_o = addr_err_q;
`else
    assign issue = pending;
`endif

    lsu_align u_align (
        .size_i       (align_size),
        .addr_lo_i    (align_lo),
        .sign_ext_i   (sign_ext_q),
        .wdata_i      (wdata_i),
        .rdata_i      (dm_rdata_i),
        .be_o         (align_be),
        .wdata_o      (align_wdata),
`ifdef UNALIGNED_TRAP_EN
        .misaligned_o (misaligned),
`endif
        .rdata_o      (align_rdata)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    stall   = 1'b1;
                    state_d = S_REQ;
`ifdef UNALIGNED_TRAP_EN
                    if (misaligned) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (dm_ack_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall is combinational from the inputs in IDLE, so reset must mask it too.
    assign stall_o = stall & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_be_q      <= '0;
            dm_wdata_q   <= '0;
            size_q       <= '0;
            addr_lo_q    <= '0;
            sign_ext_q   <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            if (in_idle && issue) begin
                dm_req_q   <= 1'b1;
                dm_we_q    <= mem_write_i;
                dm_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                dm_be_q    <= align_be;
                dm_wdata_q <= align_wdata;
                size_q     <= size_i;
                addr_lo_q  <= addr_i[1:0];
                sign_ext_q <= sign_ext_i;
            end
            if (state_q == S_REQ && dm_ack_i) begin
                dm_req_q <= 1'b0;
                if (!dm_we_q) begin
                    load_data_q  <= align_rdata;
                    load_valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef UNALIGNED_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= in_idle & pending & misaligned;
        end
    end
`endif

    assign dm_req_o     = dm_req_q;
    assign dm_we_o      = dm_we_q;
    assign dm_addr_o    = dm_addr_q;
    assign dm_be_o      = dm_be_q;
    assign dm_wdata_o   = dm_wdata_q;
    assign load_data_o  = load_data_q;
    assign load_valid_o = load_valid_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed and random transactions against a byte-lane
// reference model. Follows UNALIGNED_TRAP_EN the same way the design does.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid_i, mem_read_i, mem_write_i, sign_ext_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, dm_req_o, dm_we_o, dm_ack_i, load_valid_o;
    logic [31:0] dm_addr_o, dm_wdata_o, dm_rdata_i, load_data_o;
    logic [3:0]  dm_be_o;
`ifdef UNALIGNED_TRAP_EN
    logic        addr_err_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid_i  (mem_valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .size_i       (size_i),
        .sign_ext_i   (sign_ext_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .dm_req_o     (dm_req_o),
        .dm_we_o      (dm_we_o),
        .dm_addr_o    (dm_addr_o),
        .dm_be_o      (dm_be_o),
        .dm_wdata_o   (dm_wdata_o),
        .dm_ack_i     (dm_ack_i),
        .dm_rdata_i   (dm_rdata_i),
        .load_data_o  (load_data_o),
`ifdef UNALIGNED_TRAP_EN
        .addr_err_o   (addr_err_o),
`endif
        .load_valid_o (load_valid_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: an access covers nBytes lanes starting at the address
    // rounded down to the access size.
    function automatic int nBytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int laneStart(input logic [31:0] a, input logic [1:0] sz);
        int n  = nBytes(sz);
        int lo = int'(a[1:0]);
        return (lo / n) * n;
    endfunction

    function automatic logic [31:0] expBe(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] be = '0;
        int n = nBytes(sz);
        int s = laneStart(a, sz);
        for (int i = 0; i < 4; i++) begin
            if (i >= s && i < s + n) be[i] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] expWdata(input logic [31:0] wd, input logic [1:0] sz);
        int n = nBytes(sz);
        if (n == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] expLoad(input logic [31:0] a, input logic [1:0] sz,
                                            input logic sx, input logic [31:0] rd);
        int n = nBytes(sz);
        int s = laneStart(a, sz);
        logic [31:0] mask, v;
        if (n == 4) return rd;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (rd >> (8 * s)) & mask;
        if (sx && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic isMisaligned(input logic [31:0] a, input logic [1:0] sz);
        return (int'(a[1:0]) % nBytes(sz)) != 0;
    endfunction

    // One complete MEM-stage access; entered and left just after a rising edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                                 input logic sx, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdv, input int waits);
        logic isWrite = wr;
        mem_valid_i = 1'b1;
        mem_read_i  = rd;
        mem_write_i = wr;
        size_i      = sz;
        sign_ext_i  = sx;
        addr_i      = a;
        wdata_i     = wd;
        dm_ack_i    = 1'($urandom);
        dm_rdata_i  = $urandom;
        @(negedge clk);
        checkOutput("acc_stall", 32'(stall_o), 32'd1);
        checkOutput("acc_req", 32'(dm_req_o), 32'd0);
`ifdef UNALIGNED_TRAP_EN
        if (isMisaligned(a, sz)) begin
            @(posedge clk); #1;
            dm_ack_i = 1'b0;
            @(negedge clk);
            checkOutput("trap_stall", 32'(stall_o), 32'd0);
            checkOutput("trap_req", 32'(dm_req_o), 32'd0);
            checkOutput("trap_err", 32'(addr_err_o), 32'd1);
            checkOutput("trap_lvalid", 32'(load_valid_o), 32'd0);
            @(posedge clk); #1;
            mem_valid_i = 1'b0;
            mem_read_i  = 1'b0;
            mem_write_i = 1'b0;
            return;
        end
`endif
        for (int w = 0; w <= waits; w++) begin
            @(posedge clk); #1;
            dm_ack_i   = (w == waits);
            dm_rdata_i = (w == waits) ? rdv : $urandom;
            @(negedge clk);
            checkOutput("req", 32'(dm_req_o), 32'd1);
            checkOutput("req_stall", 32'(stall_o), 32'd1);
            checkOutput("req_we", 32'(dm_we_o), 32'(isWrite));
            checkOutput("req_addr", dm_addr_o, a & 32'hFFFF_FFFC);
            checkOutput("req_be", 32'(dm_be_o), expBe(a, sz));
            if (isWrite) checkOutput("req_wdata", dm_wdata_o, expWdata(wd, sz));
        end
        @(posedge clk); #1;
        dm_ack_i   = 1'($urandom);
        dm_rdata_i = $urandom;
        @(negedge clk);
        checkOutput("done_stall", 32'(stall_o), 32'd0);
        checkOutput("done_req", 32'(dm_req_o), 32'd0);
        checkOutput("done_lvalid", 32'(load_valid_o), 32'(!isWrite));
        if (!isWrite) checkOutput("done_ldata", load_data_o, expLoad(a, sz, sx, rdv));
`ifdef UNALIGNED_TRAP_EN
        checkOutput("done_err", 32'(addr_err_o), 32'd0);
`endif
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        dm_ack_i    = 1'b0;
    endtask

    task automatic idleCycle();
        if ($urandom_range(0, 1) == 1) begin
            mem_valid_i = 1'b1;
            mem_read_i  = 1'b0;
            mem_write_i = 1'b0;
        end else begin
            mem_valid_i = 1'b0;
            mem_read_i  = 1'($urandom);
            mem_write_i = 1'($urandom);
        end
        dm_ack_i = 1'($urandom);
        @(negedge clk);
        checkOutput("idle_stall", 32'(stall_o), 32'd0);
        checkOutput("idle_req", 32'(dm_req_o), 32'd0);
        checkOutput("idle_lvalid", 32'(load_valid_o), 32'd0);
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        dm_ack_i    = 1'b0;
    endtask

    task automatic resetMidRequest();
        mem_valid_i = 1'b1;
        mem_read_i  = 1'b1;
        mem_write_i = 1'b0;
        size_i      = 2'b10;
        sign_ext_i  = 1'b0;
        addr_i      = 32'h0000_6000;
        dm_ack_i    = 1'b0;
        @(negedge clk);
        checkOutput("rst_acc_stall", 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_pre_req", 32'(dm_req_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req_drop", 32'(dm_req_o), 32'd0);
        checkOutput("rst_stall_drop", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        mem_valid_i = 1'b0;
        mem_read_i  = 1'b0;
        dm_ack_i    = 1'b1;
        dm_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk);
        checkOutput("rst_late_req", 32'(dm_req_o), 32'd0);
        checkOutput("rst_late_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        dm_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("rst_late_lvalid", 32'(load_valid_o), 32'd0);
        checkOutput("rst_late_ldata", load_data_o, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_valid_i = 1'b1;
        mem_read_i  = 1'b1;
        mem_write_i = 1'b0;
        size_i      = 2'b00;
        sign_ext_i  = 1'b0;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        dm_ack_i    = 1'b0;
        dm_rdata_i  = 32'h0;
        @(negedge clk);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_req", 32'(dm_req_o), 32'd0);
        checkOutput("rst_we", 32'(dm_we_o), 32'd0);
        checkOutput("rst_addr", dm_addr_o, 32'd0);
        checkOutput("rst_be", 32'(dm_be_o), 32'd0);
        checkOutput("rst_wdata", dm_wdata_o, 32'd0);
        checkOutput("rst_ldata", load_data_o, 32'd0);
        checkOutput("rst_lvalid", 32'(load_valid_o), 32'd0);
`ifdef UNALIGNED_TRAP_EN
        checkOutput("rst_err", 32'(addr_err_o), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n       = 1'b1;
        mem_valid_i = 1'b0;
        mem_read_i  = 1'b0;
        idleCycle();

        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 2);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 32'h8011_2233, 0);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0, 32'h8001_7F00, 1);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_4001, 32'h0000_00A5, 32'h0, 0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5002, 32'h0, 32'h1234_5678, 0);
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 32'h0000_5100, 32'h1234_ABCD, 32'h0, 1);
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_5200, 32'h0, 32'h8765_4321, 0);
        idleCycle();
        resetMidRequest();

        for (int t = 0; t < 60; t++) begin
            logic       rd, wr;
            int         kind;
            kind = $urandom_range(0, 2);
            rd   = (kind != 1);
            wr   = (kind != 0);
            applyStimulus(rd, wr, 2'($urandom), 1'($urandom), $urandom, $urandom,
                          $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) idleCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
